// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU issue controller:
//   - ALU operation codes (4-bit ALUControl encoding)
//   - issue FSM state encoding
//   - is_legal_op / op_latency helpers
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_JMP  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SGT  = 4'd11;
  localparam logic [3:0] ALU_CLZ  = 4'd12;
  localparam logic [3:0] ALU_ROTR = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Codes 4, 5, 14 and 15 have no ALU operation behind them.
  function automatic logic is_legal_op(input logic [3:0] ctrl);
    logic legal;
    legal = 1'b1;
    case (ctrl)
      4'd4, 4'd5, 4'd14, 4'd15: legal = 1'b0;
      default:                  legal = 1'b1;
    endcase
    return legal;
  endfunction

  // Number of EXEC cycles the operands must be held for this op.
  function automatic logic [3:0] op_latency(input logic [3:0] ctrl,
                                            input logic [3:0] mul_latency);
    return (ctrl == ALU_MUL) ? mul_latency : 4'd1;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// ---------------------------------------------------------------------------
// alu_rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n : clock / asynchronous active-low reset
//   valid[1:0] : per-port request
//   enable     : arbitration allowed this cycle (grant forced to 0 otherwise)
//   grant[1:0] : one-hot grant
// A single requester always wins; on contention the pointer port wins.
// After any grant the pointer moves to the port that was not granted.
// ---------------------------------------------------------------------------
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    // grant[0] set means port 0 won, so port 1 gets priority next time.
    if (enable && (|grant)) ptr_d = grant[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Shares one 32-bit ALU between two requesters. Arbitrates round-robin,
// latches the winning op into issue registers that drive the ALU, holds them
// for the op latency (MUL_LATENCY cycles for MUL, 1 otherwise), captures the
// ALU result and returns it with port/tag on a single response channel.
//
// Ports:
//   Clk, Rst                    clock, asynchronous active-low reset
//   ReqNValid/ReqNReady         request handshake, N = 0/1
//   ReqNCtrl/ReqNA/ReqNB/ReqNTag request payload
//   RspValid/RspReady           response handshake
//   RspPort/RspTag/RspResult/RspZero response payload
//   AluCtrl/AluA/AluB           to ALU; AluResult/AluZero from ALU
//   DbgState                    current FSM state (IDLE=0, EXEC=1, RESP=2)
//   RspErr                      only with ALU_ISSUE_ILLEGAL_OP_EN
//
// Build option ALU_ISSUE_ILLEGAL_OP_EN: codes 4/5/14/15 are accepted but not
// sent to the ALU; their response carries Result=0, Zero=1, RspErr=1.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. ReqNReady is combinational from the valid inputs and FSM state
// only (never from RspReady); RspValid, once high, holds it and all Rsp*
// payload stable until the cycle RspReady is seen high.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [3:0]       Req0Ctrl,
  input  logic [31:0]      Req0A,
  input  logic [31:0]      Req0B,
  input  logic [TAG_W-1:0] Req0Tag,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [3:0]       Req1Ctrl,
  input  logic [31:0]      Req1A,
  input  logic [31:0]      Req1B,
  input  logic [TAG_W-1:0] Req1Tag,
  output logic             RspValid,
  input  logic             RspReady,
  output logic             RspPort,
  output logic [TAG_W-1:0] RspTag,
  output logic [31:0]      RspResult,
  output logic             RspZero,
  output logic [3:0]       AluCtrl,
  output logic [31:0]      AluA,
  output logic [31:0]      AluB,
  input  logic [31:0]      AluResult,
  input  logic             AluZero,
  output logic [1:0]       DbgState
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
  ,
  output logic             RspErr
`endif
);

  localparam logic [3:0] MUL_LAT4 = 4'(MUL_LATENCY);

  state_e             state_q,      state_d;
  logic [3:0]         cnt_q,        cnt_d;
  logic [3:0]         alu_ctrl_q,   alu_ctrl_d;
  logic [31:0]        alu_a_q,      alu_a_d;
  logic [31:0]        alu_b_q,      alu_b_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic               rsp_port_q,   rsp_port_d;
  logic [TAG_W-1:0]   rsp_tag_q,    rsp_tag_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic               rsp_zero_q,   rsp_zero_d;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
  logic               err_q,        err_d;
  logic               rsp_err_q,    rsp_err_d;
`endif

  logic               arb_en;
  logic [1:0]         grant;
  logic [3:0]         sel_ctrl;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [TAG_W-1:0]   sel_tag;

  // Rst is folded in so no request looks accepted while reset is held.
  assign arb_en = (state_q == IDLE) && Rst;

  alu_rr_arb2 u_arb (
    .clk    (Clk),
    .rst_n  (Rst),
    .valid  ({Req1Valid, Req0Valid}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign Req0Ready = grant[0];
  assign Req1Ready = grant[1];

  always_comb begin
    sel_ctrl = Req0Ctrl;
    sel_a    = Req0A;
    sel_b    = Req0B;
    sel_tag  = Req0Tag;
    if (grant[1]) begin
      sel_ctrl = Req1Ctrl;
      sel_a    = Req1A;
      sel_b    = Req1B;
      sel_tag  = Req1Tag;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_port_d   = rsp_port_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
    err_d        = err_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          alu_ctrl_d = sel_ctrl;
          alu_a_d    = sel_a;
          alu_b_d    = sel_b;
          rsp_port_d = grant[1];
          rsp_tag_d  = sel_tag;
          cnt_d      = op_latency(sel_ctrl, MUL_LAT4) - 4'd1;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
          err_d = !is_legal_op(sel_ctrl);
          // Illegal codes never reach the ALU: keep the previous control.
          if (!is_legal_op(sel_ctrl)) begin
            alu_ctrl_d = alu_ctrl_q;
            cnt_d      = 4'd0;
          end
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = AluResult;
          rsp_zero_d   = AluZero;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
          rsp_err_d = err_q;
          if (err_q) begin
            rsp_result_d = 32'd0;
            rsp_zero_d   = 1'b1;
          end
`endif
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      alu_ctrl_q   <= 4'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
      err_q        <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
      err_q        <= err_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign AluCtrl   = alu_ctrl_q;
  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign RspValid  = rsp_valid_q;
  assign RspPort   = rsp_port_q;
  assign RspTag    = rsp_tag_q;
  assign RspResult = rsp_result_q;
  assign RspZero   = rsp_zero_q;
  assign DbgState  = state_q;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
  assign RspErr    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl (MUL_LATENCY=3, TAG_W=4). A small
// behavioural ALU closes the loop on AluCtrl/AluA/AluB. Inputs change 1ns
// after a rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int TAG_W = 4;

  logic             Clk;
  logic             Rst;
  logic             Req0Valid, Req1Valid;
  logic             Req0Ready, Req1Ready;
  logic [3:0]       Req0Ctrl,  Req1Ctrl;
  logic [31:0]      Req0A, Req0B, Req1A, Req1B;
  logic [TAG_W-1:0] Req0Tag, Req1Tag;
  logic             RspValid, RspReady, RspPort, RspZero;
  logic [TAG_W-1:0] RspTag;
  logic [31:0]      RspResult;
  logic [3:0]       AluCtrl;
  logic [31:0]      AluA, AluB, AluResult;
  logic             AluZero;
  logic [1:0]       DbgState;
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
  logic             RspErr;
`endif

  int total = 0;
  int bad   = 0;
  logic [37:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural ALU ----------------
  always_comb begin
    case (AluCtrl)
      4'd0:    AluResult = AluA & AluB;
      4'd1:    AluResult = AluA | AluB;
      4'd2:    AluResult = AluA + AluB;
      4'd3:    AluResult = ~(AluA | AluB);
      4'd6:    AluResult = AluA - AluB;
      4'd7:    AluResult = ($signed(AluA) < $signed(AluB)) ? 32'd1 : 32'd0;
      4'd9:    AluResult = AluA * AluB;
      4'd10:   AluResult = AluA << AluB[4:0];
      4'd11:   AluResult = ($signed(AluA) > $signed(AluB)) ? 32'd1 : 32'd0;
      4'd13:   AluResult = (AluA >> AluB[4:0]) | (AluA << (6'd32 - {1'b0, AluB[4:0]}));
      default: AluResult = AluA;
    endcase
    AluZero = (AluResult == 32'd0);
  end

  alu_issue_ctrl #(.MUL_LATENCY(3), .TAG_W(TAG_W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req0Valid (Req0Valid),
    .Req0Ready (Req0Ready),
    .Req0Ctrl  (Req0Ctrl),
    .Req0A     (Req0A),
    .Req0B     (Req0B),
    .Req0Tag   (Req0Tag),
    .Req1Valid (Req1Valid),
    .Req1Ready (Req1Ready),
    .Req1Ctrl  (Req1Ctrl),
    .Req1A     (Req1A),
    .Req1B     (Req1B),
    .Req1Tag   (Req1Tag),
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspPort   (RspPort),
    .RspTag    (RspTag),
    .RspResult (RspResult),
    .RspZero   (RspZero),
    .AluCtrl   (AluCtrl),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluResult (AluResult),
    .AluZero   (AluZero),
    .DbgState  (DbgState)
`ifdef ALU_ISSUE_ILLEGAL_OP_EN
    ,
    .RspErr    (RspErr)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int port, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
    if (port == 0) begin
      Req0Valid = 1'b1; Req0Ctrl = ctrl; Req0A = a; Req0B = b; Req0Tag = tag;
    end else begin
      Req1Valid = 1'b1; Req1Ctrl = ctrl; Req1A = a; Req1B = b; Req1Tag = tag;
    end
  endtask

  task automatic clear_reqs();
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_exp(input logic port, input logic [TAG_W-1:0] tag,
                          input logic [31:0] res, input logic zero);
    exp_q.push_back({port, tag, res, zero});
  endtask

  task automatic pop_and_compare(input string tag);
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rsp"}, {26'd0, RspPort, RspTag, RspResult, RspZero}, {26'd0, e});
    end
  endtask

  // Single op on one port; RspReady must already be 1. Measures the number
  // of cycles from the accept edge to RspValid.
  task automatic issue_one(input string tag, input int port, input logic [3:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t, input logic [31:0] res,
                           input logic zero, input int lat);
    int c;
    drive_req(port, ctrl, a, b, t);
    #1;
    check({tag, "_ready"}, {62'd0, Req1Ready, Req0Ready}, (port == 0) ? 64'd1 : 64'd2);
    push_exp(port[0], t, res, zero);
    step();
    clear_reqs();
    c = 1;
    while (!RspValid && c < 20) begin
      step();
      c++;
    end
    check({tag, "_latency"}, 64'(c), 64'(lat));
    pop_and_compare(tag);
    step();
    check({tag, "_back_idle"}, {62'd0, DbgState}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0, n1, gp;
    Rst = 1'b0;
    RspReady = 1'b0;
    clear_reqs();
    Req0Ctrl = '0; Req0A = '0; Req0B = '0; Req0Tag = '0;
    Req1Ctrl = '0; Req1A = '0; Req1B = '0; Req1Tag = '0;

    // Reset held with random request traffic.
    for (int i = 0; i < 3; i++) begin
      Req0Valid = 1'($urandom_range(0, 1));
      Req1Valid = 1'($urandom_range(0, 1));
      Req0Ctrl  = 4'($urandom_range(0, 15));
      Req1Ctrl  = 4'($urandom_range(0, 15));
      Req0A = $urandom; Req0B = $urandom; Req1A = $urandom; Req1B = $urandom;
      Req0Tag = 4'($urandom_range(0, 15));
      Req1Tag = 4'($urandom_range(0, 15));
      step();
      check("rst_rspvalid", {63'd0, RspValid}, 64'd0);
      check("rst_ready", {62'd0, Req1Ready, Req0Ready}, 64'd0);
      check("rst_alu", {AluCtrl, AluA, AluB}, 64'd0);
      check("rst_rsp", {26'd0, RspPort, RspTag, RspResult, RspZero}, 64'd0);
      check("rst_state", {62'd0, DbgState}, 64'd0);
    end
    clear_reqs();
    Rst = 1'b1;
    step();

    // Priority after reset: both valid -> port 0.
    drive_req(0, 4'd2, 32'd1, 32'd1, 4'd0);
    drive_req(1, 4'd2, 32'd1, 32'd1, 4'd0);
    #1;
    check("prio_after_rst", {62'd0, Req1Ready, Req0Ready}, 64'd1);
    clear_reqs();
    #1;
    check("no_req_no_ready", {62'd0, Req1Ready, Req0Ready}, 64'd0);
    step();

    RspReady = 1'b1;
    issue_one("p0_add", 0, 4'd2, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 2);
    issue_one("p1_sub", 1, 4'd6, 32'h1234, 32'h1234, 4'd9, 32'd0, 1'b1, 2);
    issue_one("p1_rotr", 1, 4'd13, 32'h8000_0001, 32'd4, 4'd5, 32'h1800_0000, 1'b0, 2);

    // Fairness: both ports continuously valid, grants alternate 0,1,0,1...
    n0 = 0; n1 = 0;
    drive_req(0, 4'd2, 32'd0, 32'd1, 4'd0);
    drive_req(1, 4'd6, 32'd50, 32'd0, 4'd1);
    for (int k = 0; k < 6; k++) begin
      gp = k % 2;
      #1;
      check("fair_grant", {62'd0, Req1Ready, Req0Ready}, (gp == 0) ? 64'd1 : 64'd2);
      if (gp == 0) push_exp(1'b0, 4'(2 * n0), 32'(10 * n0 + 1), 1'b0);
      else         push_exp(1'b1, 4'(2 * n1 + 1), 32'(50 - n1), 1'b0);
      step();
      if (gp == 0) begin
        n0++;
        drive_req(0, 4'd2, 32'(10 * n0), 32'd1, 4'(2 * n0));
      end else begin
        n1++;
        drive_req(1, 4'd6, 32'd50, 32'(n1), 4'(2 * n1 + 1));
      end
      #1;
      check("fair_exec_ready", {62'd0, Req1Ready, Req0Ready}, 64'd0);
      step();
      check("fair_rspvalid", {63'd0, RspValid}, 64'd1);
      pop_and_compare("fair");
      step();
    end
    clear_reqs();
    step();

    // MUL: operands held T+1..T+3, response at T+4.
    drive_req(1, 4'd9, 32'd6, 32'd7, 4'd7);
    #1;
    check("mul_ready", {62'd0, Req1Ready, Req0Ready}, 64'd2);
    push_exp(1'b1, 4'd7, 32'd42, 1'b0);
    step();
    clear_reqs();
    for (int c = 1; c <= 3; c++) begin
      check("mul_hold_alu", {24'd0, AluCtrl, AluA[15:0], AluB[15:0], 4'd0},
            {24'd0, 4'd9, 16'd6, 16'd7, 4'd0});
      check("mul_no_rsp", {62'd0, DbgState, RspValid}, {62'd0, 2'd1, 1'b0});
      step();
    end
    check("mul_rspvalid", {63'd0, RspValid}, 64'd1);
    pop_and_compare("mul");
    step();

    // Backpressure: response held while RspReady=0, no requests accepted.
    RspReady = 1'b0;
    drive_req(0, 4'd0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2);
    #1;
    check("bp_ready_ignores_rspready", {62'd0, Req1Ready, Req0Ready}, 64'd1);
    push_exp(1'b0, 4'd2, 32'h0000_00F0, 1'b0);
    step();
    clear_reqs();
    step();
    drive_req(0, 4'd2, 32'd1, 32'd1, 4'd4);
    drive_req(1, 4'd2, 32'd2, 32'd2, 4'd6);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold", {26'd0, RspValid, RspTag, RspResult, RspPort},
            {26'd0, 1'b1, 4'd2, 32'h0000_00F0, 1'b0});
      check("bp_ready_low", {62'd0, Req1Ready, Req0Ready}, 64'd0);
      step();
    end
    pop_and_compare("bp");
    RspReady = 1'b1;
    step();
    check("bp_release", {62'd0, DbgState, RspValid}, 64'd0);
    // Last grant was port 0, so port 1 now has priority.
    check("bp_next_prio", {62'd0, Req1Ready, Req0Ready}, 64'd2);
    clear_reqs();
    step();

    // Reset in the middle of a MUL: response dropped, pointer back to port 0.
    drive_req(0, 4'd9, 32'd3, 32'd3, 4'd1);
    step();
    clear_reqs();
    step();
    check("midrst_in_exec", {62'd0, DbgState}, 64'd1);
    Rst = 1'b0;
    #1;
    check("midrst_async", {26'd0, DbgState, AluCtrl, RspValid, 31'd0}, 64'd0);
    step();
    step();
    Rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("midrst_no_rsp", {63'd0, RspValid}, 64'd0);
    end
    drive_req(0, 4'd2, 32'd1, 32'd1, 4'd0);
    drive_req(1, 4'd2, 32'd1, 32'd1, 4'd0);
    #1;
    check("midrst_prio", {62'd0, Req1Ready, Req0Ready}, 64'd1);
    clear_reqs();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Two-requester issue controller that shares the single 32-bit ALU between two producers, e.g. an integer pipe and a multi-cycle helper unit.
- Arbitrates round-robin, latches operands, and drives the ALU control/operand ports.
- Holds operands stable for multi-cycle MUL and returns the tagged result on one valid/ready response channel.
- Sits between the decode/issue logic and the ALU datapath.

Parameters:
- MUL_LATENCY, 3, cycles operands are held for ALUControl 9 (MUL); legal range 1..15.
- TAG_W, 4, width of the requester tag carried to the response.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- Req0Valid/Req1Valid  in  1  request valid, per port
- Req0Ready/Req1Ready  out  1  request accepted this cycle, per port
- Req0Ctrl/Req1Ctrl  in  4  ALU operation code
- Req0A/Req1A, Req0B/Req1B  in  32  operands
- Req0Tag/Req1Tag  in  TAG_W  requester tag
- RspValid  out  1  response valid
- RspReady  in  1  response consumed
- RspPort  out  1  port that issued the op
- RspTag  out  TAG_W  echoed tag
- RspResult  out  32  captured ALU result
- RspZero  out  1  captured zero flag
- AluCtrl  out  4  to ALU control
- AluA/AluB  out  32  to ALU operands
- AluResult  in  32  from ALU
- AluZero  in  1  from ALU

Behaviour:
- Reset (Rst=0, async):
  - State IDLE, priority pointer = port 0, RspValid=0.
  - All registered outputs 0 (AluCtrl/AluA/AluB/RspPort/RspTag/RspResult/RspZero).
  - An in-flight op is dropped; no response is issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid port; if both are valid, to the pointer port.
  - ReqNReady = (state==IDLE) && grantN. Combinational from valid inputs; never depends on RspReady.
  - On handshake: latch Ctrl/A/B/Tag/port into issue registers that drive AluCtrl/AluA/AluB; pointer <= non-granted port.
  - Load cnt = MUL_LATENCY-1 if Ctrl==9, else 0. Go to EXEC.
  - Pointer is unchanged when nothing is granted.
- EXEC:
  - AluCtrl/AluA/AluB held constant.
  - If cnt!=0, decrement. If cnt==0, capture AluResult/AluZero into RspResult/RspZero, set RspValid=1, go to RESP.
- RESP:
  - RspValid and all Rsp* held stable until RspReady=1.
  - On handshake: RspValid<=0, go to IDLE. Both ReqReady are low throughout.
- Latency, accept edge T to RspValid: T+2 for non-MUL ops, T+1+MUL_LATENCY for MUL. Maximum throughput is one op per 3 cycles.
- Fairness: with both ports continuously valid and RspReady=1, grants alternate 0,1,0,1... starting at port 0 after reset.
- Ops 12 (CLO/CLZ) and 13 (ROTR) are single-cycle. The B operand passes through unmodified; the count/shift field in B is the requester's responsibility.
- Issue registers keep their last values in IDLE; no zeroing between ops.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_OP_EN.
- Defined:
  - Ctrl codes 4, 5, 14, 15 are illegal. They are accepted normally but never reach the ALU; AluCtrl is held at its previous value.
  - Response arrives at T+2 with RspResult=0, RspZero=1, and extra output RspErr=1.
  - RspErr is 0 for legal ops and reset to 0.
- Undefined: all codes are forwarded to the ALU unchanged, and there is no RspErr port.

Decomposition:
- Package alu_ctrl_pkg:
  - Opcode constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_NOR=3, ALU_SUB=6, ALU_SLT=7, ALU_JMP=8, ALU_MUL=9, ALU_SLL=10, ALU_SGT=11, ALU_CLZ=12, ALU_ROTR=13.
  - State encoding IDLE/EXEC/RESP.
  - is_legal_op and op_latency helper functions.
- Sub-module alu_rr_arb2: two-way round-robin arbiter.
  - Inputs: valid[1:0], enable.
  - Outputs: grant[1:0].
  - Internal pointer advanced on enable && |grant.

Test Plan:
- Reset: Rst=0 for 3 cycles with random request inputs -> RspValid=0, ReqReady=0, all Alu*/Rsp* outputs 0. After release, port 0 has priority.
- Port0 ADD: Ctrl=2, A=5, B=7, Tag=3 accepted at T -> RspValid at T+2 with Result=12, Zero=0, Port=0, Tag=3.
- Port1 SUB: A=B=0x1234, Ctrl=6 -> Result=0, Zero=1, Port=1.
- Both ports valid for 6 ops, RspReady=1 -> grant order 0,1,0,1,0,1 with tags matching.
- MUL, MUL_LATENCY=3: A=6, B=7 at T -> AluA/AluB/AluCtrl stable T+1..T+3, RspValid at T+4, Result=42.
- Backpressure and reset mid-op:
  - RspReady=0 for 5 cycles -> Rsp* stable and both ReqReady=0; RspReady=1 -> back to IDLE next cycle.
  - Rst asserted during MUL EXEC -> no response issued; first grant after reset goes to port 0.
